// File: rtl/tpfu_pkg.sv
// tpfu_pkg: shared definitions for the TP-FU instruction sequencer.
//   Instruction word layout {opcode[23:18], dst[17:12], src1[11:6], src2/imm[5:0]},
//   opcode class decode helpers, default FU latency and sequencer state encoding.
package tpfu_pkg;

   localparam int INST_W   = 24;
   localparam int OPC_LSB  = 18;
   localparam int DST_LSB  = 12;
   localparam int SRC1_LSB = 6;
   localparam int SRC2_LSB = 0;

   localparam int ALU_LAT_DEFAULT = 4;

   // opcode[2:0] classes: 000 NOP, 001..011 reg ops, 100 reserved, 101..111 imm ops
   localparam logic [2:0] CLS_NOP  = 3'b000;
   localparam logic [2:0] CLS_RSVD = 3'b100;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Every non-NOP, non-reserved class produces a register result.
   function automatic logic op_writes(input logic [2:0] cls);
      return (cls != CLS_NOP) && (cls != CLS_RSVD);
   endfunction

   // src1 is read by exactly the classes that write.
   function automatic logic op_reads_src1(input logic [2:0] cls);
      return (cls != CLS_NOP) && (cls != CLS_RSVD);
   endfunction

   // src2 is a register only for reg ops; for imm ops the field is a literal.
   function automatic logic op_reads_src2(input logic [2:0] cls);
      return (cls[2] == 1'b0) && (cls != CLS_NOP);
   endfunction

endpackage

// File: rtl/tpfu_scoreboard.sv
// tpfu_scoreboard: tracks in-flight writing instructions of the FU pipeline.
//   clk, rst            clock, synchronous active-high reset (cancels all in-flight entries)
//   issue_v/issue_wr    instruction on the FU input this cycle / it writes a register
//   issue_dst           its destination register
//   chk_src1/chk_src2   sources of the fetched (candidate) instruction
//   chk_rd1/chk_rd2     which of those sources are actually read
//   hazard              candidate must not issue this cycle
//   drained             nothing in flight except a retiring entry
//   wb_en/wb_addr       regfile writeback of the retiring entry
module tpfu_scoreboard
   import tpfu_pkg::*;
#(
   parameter int RF_AW   = 6,
   parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_v,
   input  logic             issue_wr,
   input  logic [RF_AW-1:0] issue_dst,
   input  logic [RF_AW-1:0] chk_src1,
   input  logic [RF_AW-1:0] chk_src2,
   input  logic             chk_rd1,
   input  logic             chk_rd2,
   output logic             hazard,
   output logic             drained,
   output logic             wb_en,
   output logic [RF_AW-1:0] wb_addr
);

   logic [ALU_LAT-1:0] sb_vld;
   logic [RF_AW-1:0]   sb_dst [ALU_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_vld <= '0;
         for (int k = 0; k < ALU_LAT; k++) sb_dst[k] <= '0;
      end else begin
         sb_vld[0] <= issue_v && issue_wr;
         sb_dst[0] <= issue_dst;
         for (int k = 1; k < ALU_LAT; k++) begin
            sb_vld[k] <= sb_vld[k-1];
            sb_dst[k] <= sb_dst[k-1];
         end
      end
   end

   // A candidate issued now reaches the FU one cycle later, so a producer only
   // blocks while it is more than one cycle from retiring. That gives the
   // instruction on the FU input plus stages 0..ALU_LAT-3; stage ALU_LAT-2
   // retires in the same cycle the consumer reaches the FU.
   always_comb begin
      hazard = 1'b0;
      if (ALU_LAT >= 2 && issue_v && issue_wr) begin
         if ((chk_rd1 && chk_src1 == issue_dst) || (chk_rd2 && chk_src2 == issue_dst))
            hazard = 1'b1;
      end
      for (int k = 0; k + 3 <= ALU_LAT; k++) begin
         if (sb_vld[k] &&
             ((chk_rd1 && chk_src1 == sb_dst[k]) || (chk_rd2 && chk_src2 == sb_dst[k])))
            hazard = 1'b1;
      end
   end

   // The retiring stage is excluded so done lands one cycle after the last writeback.
   always_comb begin
      drained = !issue_v;
      for (int k = 0; k + 2 <= ALU_LAT; k++) begin
         if (sb_vld[k]) drained = 1'b0;
      end
   end

   assign wb_en   = sb_vld[ALU_LAT-1];
   assign wb_addr = sb_dst[ALU_LAT-1];

endmodule

// File: rtl/tpfu_sequencer.sv
// tpfu_sequencer: programmable instruction sequencer in front of the TP-FU datapath.
//   clk, rst     clock, synchronous active-high reset
//   prog_we/prog_addr/prog_data   IMEM write port (honoured only while idle)
//   prog_len     instructions per batch, sampled on an accepted start
//   start        begin batch (pulse)
//   busy         batch in progress
//   done         one-cycle pulse after the last writeback of a batch
//   inst_o/inst_v   registered instruction to FU decode and its valid
//   wb_en/wb_addr   regfile writeback of the retiring instruction
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; IMEM writable
// ST_ISSUE | fetching IMEM[pc], issuing one instruction per hazard-free cycle
// ST_DRAIN | all issued, waiting for in-flight writebacks to retire
module tpfu_sequencer
   import tpfu_pkg::*;
#(
   parameter int IMEM_AW = 4,
   parameter int RF_AW   = 6,
   parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_we,
   input  logic [IMEM_AW-1:0] prog_addr,
   input  logic [23:0]        prog_data,
   input  logic [IMEM_AW:0]   prog_len,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [23:0]        inst_o,
   output logic               inst_v,
   output logic               wb_en,
   output logic [RF_AW-1:0]   wb_addr
);

   localparam int               DEPTH   = 2 ** IMEM_AW;
   localparam logic [IMEM_AW:0] DEPTH_L = (IMEM_AW + 1)'(DEPTH);

   logic [INST_W-1:0]  imem [DEPTH];
   logic [INST_W-1:0]  fetch;
   state_t             state;
   logic [IMEM_AW-1:0] pc;
   logic [IMEM_AW:0]   len;
   logic               last;
   logic               hazard;
   logic               drained;

   always_ff @(posedge clk) begin
      if (prog_we && state == ST_IDLE) imem[prog_addr] <= prog_data;
   end

   assign fetch = imem[pc];
   assign last  = ({1'b0, pc} == len - (IMEM_AW + 1)'(1));
   assign busy  = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pc     <= '0;
         len    <= '0;
         done   <= 1'b0;
         inst_v <= 1'b0;
         inst_o <= '0;
      end else begin
         done   <= 1'b0;
         inst_v <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (prog_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= ST_ISSUE;
                     pc    <= '0;
                     len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                  end
               end
            end
            ST_ISSUE: begin
               if (!hazard) begin
                  inst_o <= fetch;
                  inst_v <= 1'b1;
                  // pc stays on the final entry rather than wrapping
                  if (last) state <= ST_DRAIN;
                  else      pc    <= pc + (IMEM_AW)'(1);
               end
            end
            ST_DRAIN: begin
               if (drained) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tpfu_scoreboard #(
      .RF_AW   (RF_AW),
      .ALU_LAT (ALU_LAT)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .issue_v   (inst_v),
      .issue_wr  (op_writes(inst_o[OPC_LSB +: 3])),
      .issue_dst (inst_o[DST_LSB +: RF_AW]),
      .chk_src1  (fetch[SRC1_LSB +: RF_AW]),
      .chk_src2  (fetch[SRC2_LSB +: RF_AW]),
      .chk_rd1   (op_reads_src1(fetch[OPC_LSB +: 3])),
      .chk_rd2   (op_reads_src2(fetch[OPC_LSB +: 3])),
      .hazard    (hazard),
      .drained   (drained),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr)
   );

endmodule

// File: tb/tb_tpfu_sequencer.sv
// tb_tpfu_sequencer: directed bench for tpfu_sequencer with an expected-instruction
//   and expected-writeback scoreboard filled when batches are launched.
module tb_tpfu_sequencer;

   localparam int AW  = 4;
   localparam int RW  = 6;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [23:0]   prog_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic          busy;
   logic          done;
   logic [23:0]   inst_o;
   logic          inst_v;
   logic          wb_en;
   logic [RW-1:0] wb_addr;

   tpfu_sequencer #(.IMEM_AW(AW), .RF_AW(RW), .ALU_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_len  (prog_len),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .inst_o    (inst_o),
      .inst_v    (inst_v),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [23:0]   exp_inst [$];
   logic [RW-1:0] exp_wb   [$];
   int            iss_log  [$];
   int            wb_log   [$];
   logic [23:0]   mem_model [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [23:0] mk(input logic [5:0] opc, input logic [5:0] d,
                                      input logic [5:0] a, input logic [5:0] b);
      return {opc, d, a, b};
   endfunction

   // Writing classes are everything except 000 and 100.
   function automatic bit model_writes(input logic [23:0] i);
      logic [2:0] c;
      c = i[20:18];
      return !(c == 3'b000 || c == 3'b100);
   endfunction

   // Monitor: every issue and writeback is compared against the scoreboard head.
   always @(negedge clk) begin
      logic [31:0] e;
      if (inst_v === 1'b1) begin
         iss_log.push_back(cyc);
         e = 32'hFFFF_FFFF;
         if (exp_inst.size() > 0) e = {8'h00, exp_inst.pop_front()};
         check("inst_o", {8'h00, inst_o}, e);
      end
      if (wb_en === 1'b1) begin
         wb_log.push_back(cyc);
         e = 32'hFFFF_FFFF;
         if (exp_wb.size() > 0) e = {26'd0, exp_wb.pop_front()};
         check("wb_addr", {26'd0, wb_addr}, e);
      end
   end

   task automatic load(input int addr, input logic [23:0] data);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = addr[AW-1:0];
      prog_data = data;
      mem_model[addr] = data;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic expect_batch(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         exp_inst.push_back(mem_model[i]);
         if (model_writes(mem_model[i])) exp_wb.push_back(mem_model[i][17:12]);
      end
   endtask

   task automatic clear_logs();
      iss_log.delete();
      wb_log.delete();
   endtask

   task automatic start_batch(input int n, output int s);
      @(negedge clk);
      start    = 1'b1;
      prog_len = n[AW:0];
      s        = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int d);
      int n;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      d = cyc;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d, s2;
      rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_len = '0; start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_done",    {31'd0, done},    32'd0);
      check("rst_inst_v",  {31'd0, inst_v},  32'd0);
      check("rst_inst_o",  {8'd0, inst_o},   32'd0);
      check("rst_wb_en",   {31'd0, wb_en},   32'd0);
      check("rst_wb_addr", {26'd0, wb_addr}, 32'd0);
      rst = 1'b0;

      // 1: four independent MULs
      for (int i = 0; i < 4; i++) load(i, mk(6'h03, 6'(4 + i), 6'(i), 6'(i)));
      clear_logs();
      expect_batch(0, 4);
      start_batch(4, s);
      wait_done(60, d);
      check("t1_issues", iss_log.size(), 4);
      check("t1_wbs", wb_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t1_issue_cyc", iss_log[i], s + 2 + i);
         check("t1_wb_cyc", wb_log[i], iss_log[i] + LAT);
      end
      check("t1_done_cyc", d, wb_log[3] + 1);
      @(negedge clk);
      check("t1_done_pulse", {31'd0, done}, 32'd0);
      check("t1_busy_after", {31'd0, busy}, 32'd0);

      // 2: RAW dependency
      load(0, mk(6'h03, 6'd5, 6'd1, 6'd2));
      load(1, mk(6'h01, 6'd6, 6'd5, 6'd0));
      clear_logs();
      expect_batch(0, 2);
      start_batch(2, s);
      wait_done(60, d);
      check("t2_issues", iss_log.size(), 2);
      check("t2_first", iss_log[0], s + 2);
      check("t2_raw_gap", iss_log[1] - iss_log[0], LAT);
      check("t2_bubbles", iss_log[1] - iss_log[0] - 1, LAT - 1);
      check("t2_done_cyc", d, wb_log[1] + 1);

      // 3: imm field, NOP and reserved opcode never stall; only real ops write
      load(0, mk(6'h03, 6'd5, 6'd1, 6'd2));
      load(1, mk(6'h06, 6'd7, 6'd3, 6'd5));
      load(2, mk(6'h00, 6'd5, 6'd5, 6'd5));
      load(3, mk(6'h04, 6'd7, 6'd7, 6'd7));
      clear_logs();
      expect_batch(0, 4);
      start_batch(4, s);
      wait_done(60, d);
      check("t3_issues", iss_log.size(), 4);
      for (int i = 0; i < 4; i++) check("t3_issue_cyc", iss_log[i], s + 2 + i);
      check("t3_wbs", wb_log.size(), 2);
      check("t3_done_cyc", d, wb_log[1] + 1);

      // 4: zero length, then over-length clamp
      clear_logs();
      start_batch(0, s);
      check("t4_len0_done", {31'd0, done}, 32'd1);
      check("t4_len0_cyc", cyc, s + 1);
      check("t4_len0_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      check("t4_len0_issues", iss_log.size(), 0);
      for (int i = 0; i < 16; i++) load(i, mk(6'h03, 6'(16 + i), 6'd0, 6'd1));
      clear_logs();
      expect_batch(0, 16);
      start_batch(31, s);
      wait_done(100, d);
      check("t4_issues", iss_log.size(), 16);
      check("t4_last_issue", iss_log[15], s + 17);
      check("t4_wbs", wb_log.size(), 16);
      check("t4_done_cyc", d, wb_log[15] + 1);

      // 5: reset mid-batch, then full restart
      clear_logs();
      expect_batch(0, 6);
      start_batch(6, s);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_inst_v", {31'd0, inst_v}, 32'd0);
      repeat (8) @(negedge clk);
      check("t5_issued_before_rst", iss_log.size(), 2);
      check("t5_no_wb", wb_log.size(), 0);
      exp_inst.delete();
      exp_wb.delete();
      clear_logs();
      expect_batch(0, 6);
      start_batch(6, s);
      wait_done(60, d);
      check("t5_restart_issues", iss_log.size(), 6);
      check("t5_restart_wbs", wb_log.size(), 6);
      check("t5_restart_done", d, wb_log[5] + 1);

      // 6: writes and start while busy ignored; start on done accepted
      clear_logs();
      expect_batch(0, 6);
      start_batch(6, s);
      prog_we = 1'b1; prog_addr = '0; prog_data = 24'hABCDEF;
      start = 1'b1; prog_len = 5'd2;
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      wait_done(60, d);
      check("t6_issues", iss_log.size(), 6);
      expect_batch(0, 2);
      start = 1'b1; prog_len = 5'd2; s2 = cyc;
      @(negedge clk);
      start = 1'b0;
      wait_done(60, d);
      check("t6_second_issues", iss_log.size(), 8);
      check("t6_second_first", iss_log[6], s2 + 2);
      check("t6_second_done", d, wb_log[7] + 1);

      check("inst_q_empty", exp_inst.size(), 0);
      check("wb_q_empty", exp_wb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
